// File: rtl/pdp1_cpu_alu_mul.sv
// pdp1_cpu_alu_mul: 4-stage pipelined shift-add multiplier for the PDP-1 MUL instruction
module pdp1_cpu_alu_mul (
    input  logic        in_clock,
    input  logic        in_reset,
    input  logic        i_start,
    input  logic [16:0] mcand,
    input  logic [16:0] mplier,
    input  logic        i_neg,
    output logic [33:0] product,
    output logic        o_neg,
    output logic        o_zero,
    output logic        o_valid
);

    logic        s0_valid, s1_valid, s2_valid;
    logic        s0_neg, s1_neg, s2_neg;
    logic [16:0] s0_mcand, s1_mcand, s2_mcand;
    logic [11:0] s0_mplier;
    logic [7:0]  s1_mplier;
    logic [3:0]  s2_mplier;
    logic [33:0] s0_acc, s1_acc, s2_acc;
    logic [33:0] sum0, sum1, sum2, sum3;

    function automatic logic [33:0] pp(input logic [16:0] mc, input logic [4:0] bits, input int base);
        logic [33:0] s;
        s = '0;
        for (int k = 0; k < 5; k++)
            if (bits[k]) s = s + ({17'd0, mc} << (base + k));
        return s;
    endfunction

    // partial sums: each stage adds its slice of multiplier bits to the running accumulator
    always_comb begin
        sum0 = pp(mcand, mplier[4:0], 0);
        sum1 = s0_acc + pp(s0_mcand, {1'b0, s0_mplier[3:0]}, 5);
        sum2 = s1_acc + pp(s1_mcand, {1'b0, s1_mplier[3:0]}, 9);
        sum3 = s2_acc + pp(s2_mcand, {1'b0, s2_mplier}, 13);
    end

    // pipeline registers: valid shifts unconditionally, data updates every cycle
    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            {s0_valid, s1_valid, s2_valid, o_valid} <= '0;
            {s0_neg, s1_neg, s2_neg, o_neg}         <= '0;
            {s0_mcand, s1_mcand, s2_mcand}          <= '0;
            s0_mplier <= '0;
            s1_mplier <= '0;
            s2_mplier <= '0;
            {s0_acc, s1_acc, s2_acc, product}       <= '0;
            o_zero    <= 1'b0;
        end else begin
            s0_valid  <= i_start;
            s0_neg    <= i_neg;
            s0_mcand  <= mcand;
            s0_mplier <= mplier[16:5];
            s0_acc    <= sum0;
            s1_valid  <= s0_valid;
            s1_neg    <= s0_neg;
            s1_mcand  <= s0_mcand;
            s1_mplier <= s0_mplier[11:4];
            s1_acc    <= sum1;
            s2_valid  <= s1_valid;
            s2_neg    <= s1_neg;
            s2_mcand  <= s1_mcand;
            s2_mplier <= s1_mplier[7:4];
            s2_acc    <= sum2;
            o_valid   <= s2_valid;
            o_neg     <= s2_neg;
            product   <= sum3;
            o_zero    <= (sum3 == 34'd0);
        end
    end

endmodule

// File: tb/tb_pdp1_cpu_alu_mul.sv
// tb_pdp1_cpu_alu_mul: scoreboard bench for the pipelined PDP-1 multiplier
module tb_pdp1_cpu_alu_mul;

    logic        in_clock = 1'b0;
    logic        in_reset = 1'b1;
    logic        i_start = 1'b0;
    logic [16:0] mcand = '0;
    logic [16:0] mplier = '0;
    logic        i_neg = 1'b0;
    logic [33:0] product;
    logic        o_neg, o_zero, o_valid;

    typedef struct {
        logic [33:0] p;
        logic        n;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  vpipe;
    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    int          seen = 0;

    pdp1_cpu_alu_mul dut (
        .in_clock(in_clock), .in_reset(in_reset), .i_start(i_start),
        .mcand(mcand), .mplier(mplier), .i_neg(i_neg),
        .product(product), .o_neg(o_neg), .o_zero(o_zero), .o_valid(o_valid)
    );

    always #5 in_clock = ~in_clock;

    task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // expected issue timing: an accepted start surfaces after the fourth edge
    always @(posedge in_clock or posedge in_reset)
        if (in_reset) vpipe <= '0;
        else vpipe <= {vpipe[2:0], i_start};

    // result monitor, sampled on the falling edge
    always @(negedge in_clock) begin
        if (in_reset) begin
            chk("rst_valid", {33'd0, o_valid}, 34'd0);
            chk("rst_product", product, 34'd0);
        end else begin
            chk("valid_timing", {33'd0, o_valid}, {33'd0, vpipe[3]});
            if (o_valid) begin
                seen++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("FAIL sb_underflow: got result 0x%0h with no issue pending", product);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", product, e.p);
                    chk("neg", {33'd0, o_neg}, {33'd0, e.n});
                    chk("zero", {33'd0, o_zero}, {33'd0, e.p == 34'd0});
                end
            end
        end
    end

    task automatic op(input logic [16:0] a, input logic [16:0] b, input logic n, input logic s);
        @(negedge in_clock);
        i_start = s;
        mcand = a;
        mplier = b;
        i_neg = n;
        if (s && !in_reset) begin
            sb.push_back('{p: {17'd0, a} * {17'd0, b}, n: n});
            issued++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(17'($urandom), 17'($urandom), 1'($urandom), 1'b0);
    endtask

    localparam logic [16:0] BND [7] = '{17'h00010, 17'h00020, 17'h00100, 17'h00200,
                                         17'h01000, 17'h02000, 17'h10000};

    initial begin
        #1;
        chk("reset_product", product, 34'd0);
        chk("reset_flags", {31'd0, o_valid, o_neg, o_zero}, 34'd0);
        repeat (2) @(negedge in_clock);
        in_reset = 1'b0;
        op(17'd3, 17'd5, 1'b1, 1'b1);
        idle(5);
        op(17'h1FFFF, 17'h1FFFF, 1'b0, 1'b1);
        op(17'h10000, 17'h00002, 1'b1, 1'b1);
        op(17'h00000, 17'h1FFFF, 1'b0, 1'b1);
        idle(5);
        for (int i = 0; i < 7; i++) op(17'h1FFFF, BND[i], i[0], 1'b1);
        idle(5);
        op(17'd3, 17'd5, 1'b0, 1'b1);
        op(17'h1FFFF, 17'h1FFFF, 1'b1, 1'b1);
        op(17'd0, 17'd7, 1'b0, 1'b1);
        op(17'h01234, 17'h00010, 1'b1, 1'b1);
        idle(6);
        op(17'd11, 17'd13, 1'b0, 1'b1);
        op(17'd17, 17'd19, 1'b1, 1'b1);
        op(17'd23, 17'd29, 1'b0, 1'b1);
        #1;
        in_reset = 1'b1;
        sb.delete();
        issued = issued - 3;
        #1;
        chk("midrst_valid", {33'd0, o_valid}, 34'd0);
        chk("midrst_product", product, 34'd0);
        chk("midrst_zero", {33'd0, o_zero}, 34'd0);
        op(17'd5, 17'd5, 1'b1, 1'b1);
        op(17'd6, 17'd6, 1'b1, 1'b1);
        @(negedge in_clock);
        i_start = 1'b0;
        in_reset = 1'b0;
        op(17'h0ABCD, 17'h1F00F, 1'b1, 1'b1);
        idle(6);
        for (int i = 0; i < 10000; i++) begin
            op(17'($urandom), 17'($urandom), 1'($urandom), 1'b1);
            if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
        end
        idle(6);
        chk("issue_count", 34'(seen), 34'(issued));
        chk("sb_drained", 34'(sb.size()), 34'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
